// File: rtl/width_gearbox.sv
// width_gearbox: packs IN_W-bit beats into OUT_W-bit words, MSB-first, valid/ready on both sides.
// Optional end-of-packet flush with zero padding and out_last when GEARBOX_FLUSH_EN is defined.
module width_gearbox #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 12,
    parameter int BUF_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
);
    localparam int CW = $clog2(BUF_W + 1);
    localparam logic [CW-1:0] IN_C  = CW'(IN_W);
    localparam logic [CW-1:0] OUT_C = CW'(OUT_W);
    localparam logic [CW-1:0] RDY_C = CW'(BUF_W - IN_W);

    if (BUF_W < IN_W + OUT_W - 1) begin : g_bad_buf
        $error("width_gearbox: BUF_W must be >= IN_W+OUT_W-1");
    end

    logic [BUF_W-1:0] acc_q, acc_d, acc_pop;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_pop;
    logic             push, pop, flush_pend_q, flush_word, last_word;

`ifdef GEARBOX_FLUSH_EN
    logic flush_pend_d;
    always_comb begin
        flush_word   = flush_pend_q && cnt_q != '0 && cnt_q < OUT_C;
        last_word    = flush_pend_q && (flush_word || cnt_q == OUT_C);
        flush_pend_d = (push && in_last) ? 1'b1 : (pop && last_word) ? 1'b0 : flush_pend_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flush_pend_q <= 1'b0;
        else        flush_pend_q <= flush_pend_d;
    end
`else
    logic unused_last;
    assign unused_last  = in_last;
    assign flush_pend_q = 1'b0;
    assign flush_word   = 1'b0;
    assign last_word    = 1'b0;
`endif

    assign in_ready  = cnt_q <= RDY_C && !flush_pend_q;
    assign out_valid = cnt_q >= OUT_C || flush_word;
    assign out_data  = acc_q[BUF_W-1 -: OUT_W];
    assign out_last  = last_word;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pop first so the incoming beat lands right below the surviving bits.
    always_comb begin
        acc_pop = pop ? acc_q << OUT_W : acc_q;
        cnt_pop = !pop ? cnt_q : last_word ? '0 : cnt_q - OUT_C;
        acc_d   = push ? acc_pop | ((BUF_W'(in_data) << (BUF_W - IN_W)) >> cnt_pop) : acc_pop;
        cnt_d   = cnt_pop + (push ? IN_C : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_width_gearbox.sv
// tb_width_gearbox: directed checks of an 8->12 and a 12->8 gearbox.
module tb_width_gearbox;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          tests = 0;
    int          fails = 0;

    logic        a_in_valid = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b0;
    logic [7:0]  a_in_data = '0;
    logic        a_in_ready, a_out_valid, a_out_last;
    logic [11:0] a_out_data;

    logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
    logic [11:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid, b_out_last;
    logic [7:0]  b_out_data;

    always #5 clk = ~clk;

    width_gearbox #(.IN_W(8), .OUT_W(12), .BUF_W(20)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last)
    );

    width_gearbox #(.IN_W(12), .OUT_W(8), .BUF_W(20)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last)
    );

    task automatic push_a(input logic [7:0] d, input logic l);
        int n = 0;
        a_in_valid = 1'b1; a_in_data = d; a_in_last = l;
        while (!a_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        tests++;
        if (a_in_ready !== 1'b1) begin
            fails++; $display("FAIL push_a %h: in_ready=%b required 1", d, a_in_ready);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic pop_a(input logic [11:0] d, input logic l, input string nm);
        int n = 0;
        while (!a_out_valid && n < 50) begin @(posedge clk); #1; n++; end
        tests++;
        if (a_out_valid !== 1'b1 || a_out_data !== d || a_out_last !== l) begin
            fails++;
            $display("FAIL %s: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                     nm, a_out_valid, a_out_data, a_out_last, d, l);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic push_b(input logic [11:0] d);
        int n = 0;
        b_in_valid = 1'b1; b_in_data = d;
        while (!b_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        tests++;
        if (b_in_ready !== 1'b1) begin
            fails++; $display("FAIL push_b %h: in_ready=%b required 1", d, b_in_ready);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic idle_a(input string nm);
        tests++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s: out_valid=%b in_ready=%b required 0 1", nm, a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        tests++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 12'h000 || a_out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_a: ready=%b valid=%b data=%h last=%b required 1 0 000 0",
                     a_in_ready, a_out_valid, a_out_data, a_out_last);
        end
        tests++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_data !== 8'h00 || b_out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_b: ready=%b valid=%b data=%h last=%b required 1 0 00 0",
                     b_in_ready, b_out_valid, b_out_data, b_out_last);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        push_a(8'hA1, 1'b0);
        push_a(8'hB2, 1'b0);
        pop_a(12'hA1B, 1'b0, "basic_w0");
        push_a(8'hC3, 1'b0);
        pop_a(12'h2C3, 1'b0, "basic_w1");
        idle_a("basic_empty");
    endtask

    task automatic test_backpressure;
        push_a(8'hA1, 1'b0);
        push_a(8'hB2, 1'b0);
        a_in_valid = 1'b1; a_in_data = 8'hC3;
        tests++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== 12'hA1B) begin
            fails++;
            $display("FAIL bp_full: ready=%b valid=%b data=%h required 0 1 a1b", a_in_ready, a_out_valid, a_out_data);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (a_in_ready !== 1'b0 || a_out_data !== 12'hA1B) begin
            fails++;
            $display("FAIL bp_hold: ready=%b data=%h required 0 a1b", a_in_ready, a_out_data);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        tests++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: ready=%b valid=%b required 1 0", a_in_ready, a_out_valid);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        pop_a(12'h2C3, 1'b0, "bp_w1");
        idle_a("bp_empty");
    endtask

    task automatic test_narrow;
        push_b(12'hABC);
        tests++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'hAB || b_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL narrow_w0: valid=%b data=%h ready=%b required 1 ab 0", b_out_valid, b_out_data, b_in_ready);
        end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        push_b(12'hDEF);
        b_out_ready = 1'b1;
        tests++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'hCD) begin
            fails++;
            $display("FAIL narrow_w1: valid=%b data=%h required 1 cd", b_out_valid, b_out_data);
        end
        @(posedge clk); #1;
        tests++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'hEF) begin
            fails++;
            $display("FAIL narrow_w2: valid=%b data=%h required 1 ef", b_out_valid, b_out_data);
        end
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        tests++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_last !== 1'b0) begin
            fails++;
            $display("FAIL narrow_empty: valid=%b ready=%b last=%b required 0 1 0", b_out_valid, b_in_ready, b_out_last);
        end
    endtask

    task automatic test_flush;
`ifdef GEARBOX_FLUSH_EN
        push_a(8'hA1, 1'b1);
        tests++;
        if (a_in_ready !== 1'b0) begin
            fails++; $display("FAIL flush_block: in_ready=%b required 0", a_in_ready);
        end
        pop_a(12'hA10, 1'b1, "flush_pad");
        idle_a("flush_pad_empty");
        push_a(8'hA1, 1'b0);
        push_a(8'hB2, 1'b0);
        pop_a(12'hA1B, 1'b0, "flush_w0");
        push_a(8'hC3, 1'b1);
        pop_a(12'h2C3, 1'b1, "flush_exact");
        idle_a("flush_exact_empty");
`else
        push_a(8'h5A, 1'b1);
        tests++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_last !== 1'b0) begin
            fails++;
            $display("FAIL nolast_ignored: ready=%b valid=%b last=%b required 1 0 0", a_in_ready, a_out_valid, a_out_last);
        end
        push_a(8'h3C, 1'b0);
        pop_a(12'h5A3, 1'b0, "nolast_w0");
        push_a(8'h00, 1'b0);
        pop_a(12'hC00, 1'b0, "nolast_w1");
        idle_a("nolast_empty");
`endif
    endtask

    task automatic test_reset_mid;
        push_a(8'hA1, 1'b0);
        push_a(8'hB2, 1'b0);
        rst_n = 1'b0;
        #1;
        tests++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 12'h000) begin
            fails++;
            $display("FAIL reset_mid: valid=%b ready=%b data=%h required 0 1 000", a_out_valid, a_in_ready, a_out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_a(8'hB2, 1'b0);
        push_a(8'hC3, 1'b0);
        pop_a(12'hB2C, 1'b0, "reset_w0");
        push_a(8'hD4, 1'b0);
        pop_a(12'h3D4, 1'b0, "reset_w1");
        idle_a("reset_empty");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_narrow;
        test_flush;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
